issue_unit: RTL and testbench

Parametrised in-order issue stage for the Tomasulo core. Each cycle it accepts at most one decoded instruction, allocates a reorder-buffer tag at the ROB tail and renames the destination register to that tag. It also reserves a slot in the adder, multiplier or branch reservation-station class, or stalls the front end with a ready/valid handshake. It owns the ROB head/tail pointers and the per-class reservation-station occupancy counters, and sits between decode and the reservation stations.

---
 rtl/issue_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_issue_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// -----------------------------------------------------------------------------
// issue_unit
//
// In-order issue stage of the Tomasulo core. Accepts at most one decoded
// instruction per cycle from decode (ready/valid), allocates the ROB entry at
// the tail, renames the destination register to that ROB tag and reserves a
// slot in the adder, multiplier or branch reservation-station class. The unit
// owns the ROB head/tail pointers, the ROB occupancy count and the per-class
// reservation-station occupancy counters.
//
// Parameters
//   ROB_DEPTH  ROB entries (>= 2); TAG_W = $clog2(ROB_DEPTH)
//   RS_ADD     adder reservation-station slots
//   RS_MUL     multiplier reservation-station slots
//   RS_BCH     branch reservation-station slots
//   REG_W      architectural register index width
//   FUNC_W     opcode width
//
// Ports
//   clk1                   sole clock, rising edge
//   rst                    synchronous active-high reset
//   in_valid / in_ready    decode handshake (in_ready is combinational)
//   rs1, rs2, rd, func     decoded instruction fields
//   rob_commit             retire the ROB head entry
//   add_rel/mul_rel/bch_rel one slot of the class freed
//   iss_valid, iss_*       registered issue packet (one cycle per accept)
//   iss_tag, iss_cls       allocated ROB index, class (0 add, 1 mul, 2 branch)
//   rat_we/rat_rd/rat_tag  rename write, same cycle and tag as the packet
//   rob_head, rob_count    registered ROB head pointer and occupancy
//   stall_cnt              cycles with in_valid & !in_ready
//
// Build option
//   ISSUE_STALL_CNT_EN     when defined, stall_cnt is a saturating 16-bit
//                          counter; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module issue_unit #(
    parameter int ROB_DEPTH = 8,
    parameter int RS_ADD    = 2,
    parameter int RS_MUL    = 2,
    parameter int RS_BCH    = 2,
    parameter int REG_W     = 4,
    parameter int FUNC_W    = 4,
    localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [REG_W-1:0]  rd,
    input  logic [FUNC_W-1:0] func,
    input  logic              rob_commit,
    input  logic              add_rel,
    input  logic              mul_rel,
    input  logic              bch_rel,
    output logic              iss_valid,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2,
    output logic [REG_W-1:0]  iss_rd,
    output logic [FUNC_W-1:0] iss_func,
    output logic [TAG_W-1:0]  iss_tag,
    output logic [1:0]        iss_cls,
    output logic              rat_we,
    output logic [REG_W-1:0]  rat_rd,
    output logic [TAG_W-1:0]  rat_tag,
    output logic [TAG_W-1:0]  rob_head,
    output logic [TAG_W:0]    rob_count,
    output logic [15:0]       stall_cnt
);

    // One common counter width wide enough for the largest class.
    localparam int RS_MAX_AM = (RS_ADD > RS_MUL) ? RS_ADD : RS_MUL;
    localparam int RS_MAX    = (RS_MAX_AM > RS_BCH) ? RS_MAX_AM : RS_BCH;
    localparam int CNT_W     = $clog2(RS_MAX + 1);

    localparam logic [1:0] CLS_ADD = 2'd0;
    localparam logic [1:0] CLS_MUL = 2'd1;
    localparam logic [1:0] CLS_BCH = 2'd2;

    // 0000/0001 -> add, 0010/0011 -> mul, everything else -> branch.
    function automatic logic [1:0] decode_cls(input logic [FUNC_W-1:0] f);
        if (f < FUNC_W'(2))
            return CLS_ADD;
        else if (f < FUNC_W'(4))
            return CLS_MUL;
        else
            return CLS_BCH;
    endfunction

    // ROB pointer increment with wrap at ROB_DEPTH-1 (depth need not be 2^n).
    function automatic logic [TAG_W-1:0] ptr_next(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(ROB_DEPTH - 1)) ? '0 : p + TAG_W'(1);
    endfunction

    // Class occupancy update. A release against an empty class is dropped so
    // the counter saturates at 0; accept plus release leaves it unchanged.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic             inc,
                                                  input logic             rel);
        logic dec;
        dec = rel && (c != '0);
        case ({inc, dec})
            2'b10:   return c + CNT_W'(1);
            2'b01:   return c - CNT_W'(1);
            default: return c;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: class decode and admission
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] head_p0;
    logic [TAG_W-1:0] tail_p0;
    logic [TAG_W:0]   count_p0;
    logic [CNT_W-1:0] add_cnt_p0;
    logic [CNT_W-1:0] mul_cnt_p0;
    logic [CNT_W-1:0] bch_cnt_p0;

    logic [1:0] cls_p0;
    logic       cls_free_p0;
    logic       rob_room_p0;
    logic       accept_p0;
    logic       commit_p0;

    assign cls_p0 = decode_cls(func);

    always_comb begin
        cls_free_p0 = 1'b0;
        case (cls_p0)
            CLS_ADD: cls_free_p0 = add_cnt_p0 < CNT_W'(RS_ADD);
            CLS_MUL: cls_free_p0 = mul_cnt_p0 < CNT_W'(RS_MUL);
            default: cls_free_p0 = bch_cnt_p0 < CNT_W'(RS_BCH);
        endcase
    end

    // Admission looks at registered state only: a same-cycle commit or
    // release does not open a slot until the following cycle.
    assign rob_room_p0 = count_p0 < (TAG_W + 1)'(ROB_DEPTH);
    assign in_ready    = rob_room_p0 && cls_free_p0;
    assign accept_p0   = in_valid && in_ready;
    assign commit_p0   = rob_commit && (count_p0 != '0);

    // ------------------------------------------------------------------
    // Stage p1: ROB/RS bookkeeping and registered issue packet
    // ------------------------------------------------------------------
    logic              vld_p1;
    logic [REG_W-1:0]  rs1_p1;
    logic [REG_W-1:0]  rs2_p1;
    logic [REG_W-1:0]  rd_p1;
    logic [FUNC_W-1:0] func_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [1:0]        cls_p1;

    always_ff @(posedge clk1) begin
        if (rst) begin
            head_p0    <= '0;
            tail_p0    <= '0;
            count_p0   <= '0;
            add_cnt_p0 <= '0;
            mul_cnt_p0 <= '0;
            bch_cnt_p0 <= '0;
            vld_p1     <= 1'b0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            rd_p1      <= '0;
            func_p1    <= '0;
            tag_p1     <= '0;
            cls_p1     <= '0;
        end else begin
            vld_p1 <= accept_p0;

            if (accept_p0) begin
                tail_p0 <= ptr_next(tail_p0);
                rs1_p1  <= rs1;
                rs2_p1  <= rs2;
                rd_p1   <= rd;
                func_p1 <= func;
                tag_p1  <= tail_p0;
                cls_p1  <= cls_p0;
            end

            if (commit_p0)
                head_p0 <= ptr_next(head_p0);

            case ({accept_p0, commit_p0})
                2'b10:   count_p0 <= count_p0 + (TAG_W + 1)'(1);
                2'b01:   count_p0 <= count_p0 - (TAG_W + 1)'(1);
                default: count_p0 <= count_p0;
            endcase

            add_cnt_p0 <= cnt_next(add_cnt_p0, accept_p0 && (cls_p0 == CLS_ADD), add_rel);
            mul_cnt_p0 <= cnt_next(mul_cnt_p0, accept_p0 && (cls_p0 == CLS_MUL), mul_rel);
            bch_cnt_p0 <= cnt_next(bch_cnt_p0, accept_p0 && (cls_p0 == CLS_BCH), bch_rel);
        end
    end

    assign iss_valid = vld_p1;
    assign iss_rs1   = rs1_p1;
    assign iss_rs2   = rs2_p1;
    assign iss_rd    = rd_p1;
    assign iss_func  = func_p1;
    assign iss_tag   = tag_p1;
    assign iss_cls   = cls_p1;

    // The rename write is the same registered event as the issue packet.
    assign rat_we    = vld_p1;
    assign rat_rd    = rd_p1;
    assign rat_tag   = tag_p1;

    assign rob_head  = head_p0;
    assign rob_count = count_p0;

`ifdef ISSUE_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_p1;

    always_ff @(posedge clk1) begin
        if (rst)
            stall_p1 <= '0;
        else if (in_valid && !in_ready)
            stall_p1 <= sat_inc16(stall_p1);
    end

    assign stall_cnt = stall_p1;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_issue_unit
//
// Self-checking bench for issue_unit. A predictor process keeps an abstract
// model of the issue stage (ROB as head + occupancy, class occupancy array)
// and pushes the expected issue packet into a queue on every accept; a
// separate monitor pops and compares whenever the DUT presents iss_valid.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_issue_unit;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;
    localparam int REG_W     = 4;
    localparam int FUNC_W    = 4;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [REG_W-1:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [FUNC_W-1:0] func = '0;
    logic              rob_commit = 1'b0, add_rel = 1'b0, mul_rel = 1'b0, bch_rel = 1'b0;
    logic              iss_valid;
    logic [REG_W-1:0]  iss_rs1, iss_rs2, iss_rd;
    logic [FUNC_W-1:0] iss_func;
    logic [TAG_W-1:0]  iss_tag;
    logic [1:0]        iss_cls;
    logic              rat_we;
    logic [REG_W-1:0]  rat_rd;
    logic [TAG_W-1:0]  rat_tag;
    logic [TAG_W-1:0]  rob_head;
    logic [TAG_W:0]    rob_count;
    logic [15:0]       stall_cnt;

    issue_unit #(
        .ROB_DEPTH(ROB_DEPTH), .RS_ADD(2), .RS_MUL(2), .RS_BCH(2),
        .REG_W(REG_W), .FUNC_W(FUNC_W)
    ) dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func),
        .rob_commit(rob_commit), .add_rel(add_rel), .mul_rel(mul_rel), .bch_rel(bch_rel),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_tag(iss_tag), .iss_cls(iss_cls),
        .rat_we(rat_we), .rat_rd(rat_rd), .rat_tag(rat_tag),
        .rob_head(rob_head), .rob_count(rob_count), .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     rs1, rs2, rd, func, tag, cls;
        longint due;
    } pkt_t;

    pkt_t   exp_q[$];
    longint cyc = 0;
    bit     model_on = 0;
    int     m_head = 0;
    int     m_count = 0;
    int     m_cnt[3] = '{0, 0, 0};
    int     m_lim[3] = '{2, 2, 2};
    int     m_stall = 0;

    always @(posedge clk1) cyc <= cyc + 1;

    function automatic int cls_of(input int f);
        if (f <= 1) return 0;
        if (f <= 3) return 1;
        return 2;
    endfunction

    // Predictor: compare registered state against the model, then advance
    // the model by what the coming edge will do.
    always @(negedge clk1) begin
        int  c;
        bit  rdy, acc, cm;
        bit  rel[3];
        c   = cls_of(int'(func));
        rdy = (m_count < ROB_DEPTH) && (m_cnt[c] < m_lim[c]);
        if (model_on) begin
            check("in_ready", in_ready, rdy);
            check("rob_count", rob_count, m_count);
            check("rob_head", rob_head, m_head);
            check("stall_cnt", stall_cnt, m_stall);
        end
        if (rst) begin
            model_on = 1;
            m_head = 0; m_count = 0; m_stall = 0;
            m_cnt = '{0, 0, 0};
        end else if (model_on) begin
            acc = in_valid && rdy;
            if (acc) begin
                pkt_t p;
                p.rs1 = int'(rs1); p.rs2 = int'(rs2); p.rd = int'(rd);
                p.func = int'(func); p.cls = c;
                p.tag = (m_head + m_count) % ROB_DEPTH;
                p.due = cyc + 1;
                exp_q.push_back(p);
            end
`ifdef ISSUE_STALL_CNT_EN
            if (in_valid && !rdy && m_stall < 65535) m_stall++;
`endif
            cm = rob_commit && (m_count > 0);
            if (cm) m_head = (m_head + 1) % ROB_DEPTH;
            m_count = m_count + int'(acc) - int'(cm);
            rel[0] = add_rel; rel[1] = mul_rel; rel[2] = bch_rel;
            for (int k = 0; k < 3; k++) begin
                int was;
                was = m_cnt[k];
                if (acc && c == k) m_cnt[k]++;
                if (rel[k] && was > 0) m_cnt[k]--;
            end
        end
    end

    // Monitor: consume the DUT's issue packets.
    always @(negedge clk1) begin
        if (model_on) begin
            check("rat_we_eq_valid", rat_we, iss_valid);
            if (iss_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    pkt_t p;
                    p = exp_q.pop_front();
                    check("issue_cycle", cyc, p.due);
                    check("iss_rs1", iss_rs1, p.rs1);
                    check("iss_rs2", iss_rs2, p.rs2);
                    check("iss_rd", iss_rd, p.rd);
                    check("iss_func", iss_func, p.func);
                    check("iss_tag", iss_tag, p.tag);
                    check("iss_cls", iss_cls, p.cls);
                    check("rat_rd", rat_rd, p.rd);
                    check("rat_tag", rat_tag, p.tag);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                check("missing_issue", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input int f, input int d, input bit c,
                          input bit a, input bit m, input bit b, input bit r);
        in_valid = v; func = f[3:0]; rd = d[3:0];
        rs1 = 4'($urandom); rs2 = 4'($urandom);
        rob_commit = c; add_rel = a; mul_rel = m; bch_rel = b; rst = r;
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    int exp_stall;

    initial begin
        do_reset();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset_count", rob_count, 0);
        check("reset_head", rob_head, 0);
        check("reset_valid", iss_valid, 0);
        check("reset_ready", in_ready, 1);
        tick();

        // Three adds against RS_ADD=2; the third waits for add_rel.
        set_in(1, 0, 1, 0, 0, 0, 0, 0); tick();
        set_in(1, 0, 2, 0, 0, 0, 0, 0); tick();
        set_in(1, 0, 3, 0, 1, 0, 0, 0); #2;
        check("add_full_ready", in_ready, 0);
        tick();
        set_in(1, 0, 3, 0, 0, 0, 0, 0); #2;
        check("add_retry_ready", in_ready, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("add_retry_tag", iss_tag, 2);
        check("add_retry_valid", iss_valid, 1);
        tick();

        // Fill the ROB with mixed classes, then commit while holding one.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            int f;
            f = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 2 : 4);
            set_in(1, f, i, 0, i > 0, i > 0, i > 0, 0);
            tick();
        end
        set_in(1, 0, 9, 1, 0, 0, 0, 0); #2;
        check("rob_full_count", rob_count, 8);
        check("rob_full_ready", in_ready, 0);
        tick();
        set_in(1, 0, 9, 0, 0, 0, 0, 0); #2;
        check("after_commit_count", rob_count, 7);
        check("after_commit_ready", in_ready, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("wrap_tag", iss_tag, 0);
        check("wrap_rd", iss_rd, 9);
        tick();

        // Accept and release on the mul class in the same cycle.
        do_reset();
        set_in(1, 2, 5, 0, 0, 0, 0, 0); tick();
        set_in(1, 3, 6, 0, 0, 1, 0, 0); tick();
        set_in(1, 2, 7, 0, 0, 0, 0, 0); #2;
        check("mul_cls", iss_cls, 1);
        check("mul_cnt_held_ready", in_ready, 1);
        tick();
        set_in(1, 2, 8, 0, 0, 0, 0, 0); #2;
        check("mul_full_ready", in_ready, 0);
        tick();

        // Commit and release against empty state are ignored.
        do_reset();
        set_in(0, 4, 0, 1, 0, 0, 1, 0); tick();
        set_in(0, 4, 0, 0, 0, 0, 0, 0); #2;
        check("empty_commit_count", rob_count, 0);
        check("empty_commit_head", rob_head, 0);
        tick();
        set_in(1, 4, 1, 0, 0, 0, 0, 0); tick();
        set_in(1, 9, 2, 0, 0, 0, 0, 0); tick();
        set_in(1, 15, 3, 0, 0, 0, 0, 0); #2;
        check("bch_full_ready", in_ready, 0);
        tick();

        // Reset in the middle of a stream of accepts.
        do_reset();
        set_in(1, 0, 1, 0, 0, 0, 0, 0); tick();
        set_in(1, 2, 2, 0, 0, 0, 0, 0); tick();
        set_in(1, 4, 3, 0, 0, 0, 0, 1); tick();
        set_in(1, 4, 11, 0, 0, 0, 0, 0); #2;
        check("midrst_valid", iss_valid, 0);
        check("midrst_rat_we", rat_we, 0);
        check("midrst_tag", iss_tag, 0);
        check("midrst_rd", iss_rd, 0);
        check("midrst_count", rob_count, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("post_rst_tag", iss_tag, 0);
        check("post_rst_rd", iss_rd, 11);
        tick();

        // Five stalled cycles.
        do_reset();
        set_in(1, 0, 1, 0, 0, 0, 0, 0); tick();
        set_in(1, 1, 2, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 3, 0, 0, 0, 0, 0); tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #2;
`ifdef ISSUE_STALL_CNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        check("stall_cnt_5", stall_cnt, exp_stall);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 99) < 70, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), $urandom_range(0, 99) < 40,
                   $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                   $urandom_range(0, 99) < 30, $urandom_range(0, 199) == 0);
            tick();
        end

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
